// File: rtl/half_duplex_port.sv
// half_duplex_port: one endpoint of a half-duplex shared tristate bus.
// Two instances face each other across one bus. A priority bit and an
// ownership handshake (own/req) guarantee a single driver at a time, with a
// turnaround gap between owners. Words leave through a valid/ready handshake
// and arrive whenever the peer strobes the bus.
module half_duplex_port #(
  parameter int WIDTH     = 4,
  parameter int MASTER    = 0,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  inout  wire  [WIDTH-1:0] bus_io,
  output logic             own_o,
  output logic             strb_o,
  output logic             req_o,
  input  logic             peer_own_i,
  input  logic             peer_strb_i,
  input  logic             peer_req_i
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  localparam logic [1:0] ST_LISTEN = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_TURN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc_s;
  logic [TW-1:0]    turn_q, turn_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             leave_drive_s;
  logic             own_s;

  assign cnt_inc_s = cnt_q + CW'(1);

  // Ownership FSM, burst counter, turnaround timer and priority next state
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    turn_d        = turn_q;
    prio_d        = prio_q;
    leave_drive_s = 1'b0;
    case (state_q)
      ST_LISTEN: begin
        // Grant only when the peer is off the bus and either idle or yielding.
        if (tx_valid_i && !peer_own_i && (!peer_req_i || prio_q)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          state_d = ST_LISTEN;
        end
      end
      ST_DRIVE: begin
        // A missing word ends the ownership period rather than pausing it.
        if (!tx_valid_i) begin
          state_d       = ST_TURN;
          turn_d        = '0;
          leave_drive_s = 1'b1;
        end else if (cnt_inc_s == CW'(MAX_BURST)) begin
          state_d       = ST_TURN;
          turn_d        = '0;
          cnt_d         = cnt_inc_s;
          leave_drive_s = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_TURN: begin
        if (turn_q == TW'(TURN_CYC - 1)) begin
          state_d = ST_LISTEN;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_LISTEN;
      end
    endcase
    // Seeing the peer own the bus hands priority to this end; giving the
    // bus up hands it away, so the two ends stay complementary.
    if (peer_own_i) begin
      prio_d = 1'b1;
    end else if (leave_drive_s) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Receive capture, independent of the local ownership state
  always_comb begin
    rx_valid_d = peer_strb_i;
    if (peer_strb_i) begin
      rx_data_d = bus_io;
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_LISTEN;
      cnt_q      <= '0;
      turn_q     <= '0;
      prio_q     <= (MASTER != 0) ? 1'b1 : 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      turn_q     <= turn_d;
      prio_q     <= prio_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Outputs decode the registered state only; reset forces them idle so the
  // bus is released for every cycle reset is held.
  assign own_s      = (state_q == ST_DRIVE) && !reset_i;
  assign own_o      = own_s;
  assign strb_o     = own_s && tx_valid_i;
  assign tx_ready_o = own_s;
  assign req_o      = !reset_i &&
                      ((state_q == ST_DRIVE) || ((state_q == ST_LISTEN) && tx_valid_i));
  assign bus_io     = own_s ? tx_data_i : {WIDTH{1'bz}};
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_half_duplex_port.sv
// Bench for half_duplex_port: a master/slave pair on one shared bus, checked
// against a transaction-level model of ownership periods plus a directed table.
module tb_half_duplex_port;

  localparam int MAXB  = 4;
  localparam int TURNC = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] m_data, s_data;
  logic       m_valid, s_valid;
  wire  [3:0] bus;
  logic       m_ready, m_rxv, m_own, m_strb, m_req;
  logic       s_ready, s_rxv, s_own, s_strb, s_req;
  logic [3:0] m_rxd, s_rxd;

  int tests  = 0;
  int failed = 0;

  half_duplex_port #(.WIDTH(4), .MASTER(1), .MAX_BURST(MAXB), .TURN_CYC(TURNC)) u_m (
    .clk_i(clk), .reset_i(reset), .tx_data_i(m_data), .tx_valid_i(m_valid),
    .tx_ready_o(m_ready), .rx_data_o(m_rxd), .rx_valid_o(m_rxv), .bus_io(bus),
    .own_o(m_own), .strb_o(m_strb), .req_o(m_req),
    .peer_own_i(s_own), .peer_strb_i(s_strb), .peer_req_i(s_req));

  half_duplex_port #(.WIDTH(4), .MASTER(0), .MAX_BURST(MAXB), .TURN_CYC(TURNC)) u_s (
    .clk_i(clk), .reset_i(reset), .tx_data_i(s_data), .tx_valid_i(s_valid),
    .tx_ready_o(s_ready), .rx_data_o(s_rxd), .rx_valid_o(s_rxv), .bus_io(bus),
    .own_o(s_own), .strb_o(s_strb), .req_o(s_req),
    .peer_own_i(m_own), .peer_strb_i(m_strb), .peer_req_i(m_req));

  always #5 clk = ~clk;

  // Reference model: index 0 = master, 1 = slave. Each end is either holding
  // an ownership period (with a word tally), cooling down, or free to request.
  bit         mo_owning[2];
  int         mo_words[2];
  int         mo_cool[2];
  bit         mo_prio[2];
  bit         mo_rxv[2];
  logic [3:0] mo_rxd[2];
  bit         e_own[2], e_strb[2], e_req[2];
  int         m_run, s_run;

  task automatic model_reset();
    for (int e = 0; e < 2; e++) begin
      mo_owning[e] = 1'b0; mo_words[e] = 0; mo_cool[e] = 0;
      mo_prio[e] = (e == 0); mo_rxv[e] = 1'b0; mo_rxd[e] = 4'h0;
    end
  endtask

  task automatic model_outputs();
    bit v[2];
    v[0] = m_valid; v[1] = s_valid;
    for (int e = 0; e < 2; e++) begin
      e_own[e]  = !reset && mo_owning[e];
      e_strb[e] = e_own[e] && v[e];
      e_req[e]  = !reset && (mo_owning[e] || (mo_cool[e] == 0 && v[e]));
    end
  endtask

  task automatic model_update();
    bit v[2];
    logic [3:0] d[2];
    v[0] = m_valid; v[1] = s_valid; d[0] = m_data; d[1] = s_data;
    if (reset) begin
      model_reset();
    end else begin
      for (int e = 0; e < 2; e++) begin
        int p;
        bit leave;
        p = 1 - e;
        leave = 1'b0;
        mo_rxv[e] = e_strb[p];
        if (e_strb[p]) mo_rxd[e] = d[p];
        if (mo_owning[e]) begin
          if (!v[e]) leave = 1'b1;
          else begin
            mo_words[e]++;
            if (mo_words[e] == MAXB) leave = 1'b1;
          end
          if (leave) begin mo_owning[e] = 1'b0; mo_cool[e] = TURNC; end
        end else if (mo_cool[e] > 0) begin
          mo_cool[e]--;
        end else if (v[e] && !e_own[p] && (!e_req[p] || mo_prio[e])) begin
          mo_owning[e] = 1'b1; mo_words[e] = 0;
        end
        if (e_own[p]) mo_prio[e] = 1'b1;
        else if (leave) mo_prio[e] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    model_outputs();
    chk("own_m", 32'(m_own), 32'(e_own[0]));
    chk("own_s", 32'(s_own), 32'(e_own[1]));
    chk("strb_m", 32'(m_strb), 32'(e_strb[0]));
    chk("strb_s", 32'(s_strb), 32'(e_strb[1]));
    chk("req_m", 32'(m_req), 32'(e_req[0]));
    chk("req_s", 32'(s_req), 32'(e_req[1]));
    chk("ready_m", 32'(m_ready), 32'(e_own[0]));
    chk("ready_s", 32'(s_ready), 32'(e_own[1]));
    chk("rxv_m", 32'(m_rxv), 32'(mo_rxv[0]));
    chk("rxv_s", 32'(s_rxv), 32'(mo_rxv[1]));
    chk("rxd_m", 32'(m_rxd), 32'(mo_rxd[0]));
    chk("rxd_s", 32'(s_rxd), 32'(mo_rxd[1]));
    chk("excl", 32'(m_own & s_own), 32'd0);
    if (e_own[0]) chk("bus_m", 32'(bus), 32'(m_data));
    if (e_own[1]) chk("bus_s", 32'(bus), 32'(s_data));
  endtask

  task automatic cyc_sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cyc_advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    cyc_sample();
    cyc_advance();
  endtask

  typedef struct {
    bit rst; bit mv; logic [3:0] md; bit sv; logic [3:0] sd;
    bit m_own; bit s_own; bit m_strb; bit s_strb;
    bit m_rxv; logic [3:0] m_rxd; bit s_rxv; logic [3:0] s_rxd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Master sends E then 3 then idles; slave then sends 5 alone.
    tbl[0] = '{1'b1, 1'b1, 4'hE, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[1] = '{1'b0, 1'b1, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[2] = '{1'b0, 1'b1, 4'hE, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[3] = '{1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'hE};
    tbl[4] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h3};
    tbl[5] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h3};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h3};
    tbl[7] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h3};
    tbl[8] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 4'h3};
    tbl[9] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 4'h3};

    // Reset held with both ends requesting: nothing may drive or request.
    reset = 1'b1; m_valid = 1'b1; s_valid = 1'b1; m_data = 4'h9; s_data = 4'h6;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc_sample();
      chk("rst_own", 32'({m_own, s_own}), 32'd0);
      chk("rst_req", 32'({m_req, s_req}), 32'd0);
      chk("rst_rxv", 32'({m_rxv, s_rxv}), 32'd0);
      cyc_advance();
    end

    // Directed table
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst; m_valid = tbl[i].mv; m_data = tbl[i].md;
      s_valid = tbl[i].sv; s_data = tbl[i].sd;
      cyc_sample();
      chk($sformatf("tbl%0d_mown", i), 32'(m_own), 32'(tbl[i].m_own));
      chk($sformatf("tbl%0d_sown", i), 32'(s_own), 32'(tbl[i].s_own));
      chk($sformatf("tbl%0d_mstrb", i), 32'(m_strb), 32'(tbl[i].m_strb));
      chk($sformatf("tbl%0d_sstrb", i), 32'(s_strb), 32'(tbl[i].s_strb));
      chk($sformatf("tbl%0d_mrx", i), 32'({m_rxv, m_rxd}), 32'({tbl[i].m_rxv, tbl[i].m_rxd}));
      chk($sformatf("tbl%0d_srx", i), 32'({s_rxv, s_rxd}), 32'({tbl[i].s_rxv, tbl[i].s_rxd}));
      cyc_advance();
    end

    // Continuous contention: master first after reset, then alternation.
    reset = 1'b1; m_valid = 1'b1; s_valid = 1'b1;
    cyc();
    reset = 1'b0;
    m_run = 0; s_run = 0;
    for (int i = 0; i < 30; i++) begin
      m_data = 4'($urandom); s_data = 4'($urandom);
      cyc_sample();
      if (i == 1) chk("master_first", 32'({m_own, s_own}), 32'b10);
      m_run = m_strb ? m_run + 1 : 0;
      s_run = s_strb ? s_run + 1 : 0;
      chk("burst_len", 32'((m_run <= MAXB) && (s_run <= MAXB)), 32'd1);
      cyc_advance();
    end

    // Reset while the master is mid-burst.
    for (int i = 0; i < 20; i++) begin
      cyc_sample();
      if (m_own) begin cyc_advance(); break; end
      cyc_advance();
      if (i == 19) chk("wait_m_own", 32'd0, 32'd1);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc_sample();
    chk("post_rst_own", 32'({m_own, m_strb, s_own}), 32'd0);
    cyc_advance();
    cyc_sample();
    chk("rearb_master", 32'({m_own, s_own}), 32'b10);
    cyc_advance();

    // Slave requests right after master's period ends and wins on priority.
    s_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();                       // grant cycle
    for (int i = 0; i < MAXB - 1; i++) begin
      cyc_sample();
      chk("m_period", 32'(m_own), 32'd1);
      cyc_advance();
    end
    cyc();                       // master's last word
    s_valid = 1'b1;              // first master TURN cycle
    cyc_sample();
    chk("m_turn", 32'({m_own, s_own}), 32'd0);
    cyc_advance();
    for (int i = 0; i < MAXB; i++) begin
      cyc_sample();
      chk("s_period", 32'({m_own, s_own}), 32'b01);
      cyc_advance();
    end
    cyc_sample();
    chk("s_turn", 32'({m_own, s_own}), 32'd0);
    cyc_advance();
    cyc_sample();
    chk("m_back", 32'({m_own, s_own}), 32'b10);
    cyc_advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(63) == 0);
      m_valid = ($urandom_range(3) != 0);
      s_valid = ($urandom_range(3) != 0);
      m_data  = 4'($urandom);
      s_data  = 4'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
